ps2_scancode_rx: RTL

//   PS/2 keyboard receiver feeding the game FSM's 30-bit scancode input. Synchronises and
//   de-glitches ps2_clk/ps2_data, deframes 11-bit device-to-host frames, checks parity/stop,
//   and tracks E0/F0 prefixes. Presents the held key as a level (0 when no key is held),
//   so downstream logic compares scancode against make codes directly.

---
 rtl/ps2_scancode_rx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, deframes
// 11-bit device-to-host frames, checks parity/stop, tracks E0/F0 prefixes and
// presents the currently held key as a level on scancode (0 = no key held).
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [29:0] scancode,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;

    logic                   filt_q, filt_d;
    logic [FLT_W-1:0]       filt_cnt_q, filt_cnt_d;
    logic                   fall;

    state_t                 state_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   par_q;
    logic [TMO_W-1:0]       tmo_q;

    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [15:0]            code_q, code_d;
    logic                   kv_q, kv_d;
    logic                   fe_q, fe_d;

    logic                   frame_ok;
    logic                   frame_bad;
    logic                   tmo_hit;
    logic [15:0]            new_code;

    // Status/ack bytes the keyboard sends that never represent a key press
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFC) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Metastability chains for both asynchronous PS/2 lines; idle level is high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FLT_LAST) begin
                filt_d     = clk_s;
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // A falling edge is the cycle in which the filtered clock is about to go low
    assign fall = filt_q & ~filt_d;

    assign frame_ok  = fall && (state_q == STOP) && data_s && (^{shift_q, par_q});
    assign frame_bad = fall && (state_q == STOP) && !(data_s && (^{shift_q, par_q}));
    assign tmo_hit   = (state_q != IDLE) && !fall && (tmo_q == TMO_LAST);
    assign new_code  = {(ext_q ? 8'hE0 : 8'h00), shift_q};

    // Byte decoder: prefix tracking and held-key update for an accepted frame
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        code_d = code_q;
        kv_d   = 1'b0;
        fe_d   = frame_bad || tmo_hit;
        if (frame_ok) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (is_ignored(shift_q) && !ext_q && !brk_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!brk_q) begin
                    code_d = new_code;
                    kv_d   = 1'b1;
                end else if ((code_q != 16'h0) && (new_code == code_q)) begin
                    code_d = 16'h0;
                    kv_d   = 1'b1;
                end
            end
        end
        if (tmo_hit) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    // Frame FSM with idle timeout, plus registered decoder outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            code_q    <= '0;
            kv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            code_q <= code_d;
            kv_q   <= kv_d;
            fe_q   <= fe_d;

            if ((state_q == IDLE) || fall || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (tmo_hit) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q <= {data_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    PARITY: begin
                        par_q   <= data_s;
                        state_q <= STOP;
                    end
                    default: begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign scancode  = {14'b0, code_q};
    assign key_valid = kv_q;
    assign frame_err = fe_q;

endmodule
